// File: rtl/store_pkg.sv
// Shared encodings for the halfword store path: op codes, FSM states, saturation limits.
package store_pkg;
  localparam logic OP_SH = 1'b0;
  localparam logic OP_SW = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
endpackage

// File: rtl/narrow_check_32to16.sv
// Inverse of the 16->32 sign extender: flags whether a word survives narrowing and yields the halfword.
// Build option STORE_SAT_NARROW_EN: lossy values saturate instead of truncating.
module narrow_check_32to16
  import store_pkg::*;
(
  input  logic [31:0] data_i,
  output logic        lossless_o,
  output logic [15:0] narrowed_o
);
  assign lossless_o = (data_i[31:16] == {16{data_i[15]}});

`ifdef STORE_SAT_NARROW_EN
  assign narrowed_o = lossless_o ? data_i[15:0] : (data_i[31] ? SAT_NEG : SAT_POS);
`else
  assign narrowed_o = data_i[15:0];
`endif
endmodule

// File: rtl/halfword_store_narrower.sv
// Narrows SH/SW stores onto a 16-bit memory write bus; SW becomes two halfword beats.
// Build option STORE_SAT_NARROW_EN selects saturating SH narrowing in narrow_check_32to16.
module halfword_store_narrower
  import store_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int HI_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              trunc_err,
  output logic              align_err
);
  state_e              state_q;
  logic                op_q;
  logic [15:0]         second_q;
  logic                trunc_pend_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [15:0]         mem_wdata_q;
  logic                done_q;
  logic                trunc_err_q;
  logic                align_err_q;

  logic                lossless;
  logic [15:0]         narrowed;
  logic                misaligned;
  logic [15:0]         sw_first;
  logic [15:0]         sw_second;

  narrow_check_32to16 u_check (
    .data_i     (in_data),
    .lossless_o (lossless),
    .narrowed_o (narrowed)
  );

  assign misaligned = (in_op == OP_SW) ? (in_addr[1:0] != 2'b00) : in_addr[0];
  assign sw_first   = (HI_FIRST != 0) ? in_data[31:16] : in_data[15:0];
  assign sw_second  = (HI_FIRST != 0) ? in_data[15:0]  : in_data[31:16];

  assign in_ready  = (state_q == IDLE) && !rst;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign trunc_err = trunc_err_q;
  assign align_err = align_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_SH;
      second_q     <= '0;
      trunc_pend_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      trunc_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            if (misaligned) begin
              state_q     <= FIN;
              done_q      <= 1'b1;
              align_err_q <= 1'b1;
            end else begin
              state_q      <= BEAT0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= in_addr;
              mem_wdata_q  <= (in_op == OP_SW) ? sw_first : narrowed;
              second_q     <= sw_second;
              trunc_pend_q <= (in_op == OP_SH) && !lossless;
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (op_q == OP_SW) begin
              state_q     <= BEAT1;
              mem_addr_q  <= mem_addr_q + ADDR_W'(2);
              mem_wdata_q <= second_q;
            end else begin
              state_q     <= FIN;
              mem_we_q    <= 1'b0;
              done_q      <= 1'b1;
              trunc_err_q <= trunc_pend_q;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state_q  <= FIN;
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        FIN: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          trunc_err_q <= 1'b0;
          align_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_halfword_store_narrower.sv
// Directed bench for halfword_store_narrower (ADDR_W=16, HI_FIRST=0); samples 1ns after each rising edge.
module tb_halfword_store_narrower;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [15:0] in_addr;
  logic [31:0] in_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        trunc_err;
  logic        align_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  halfword_store_narrower #(.ADDR_W(16), .HI_FIRST(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .trunc_err (trunc_err),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) we_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [15:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_data  = data;
    step();
    in_valid = 1'b0;
    in_data  = 32'hxxxx_xxxx;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_addr = '0; in_data = '0; mem_ack = 1'b1;
    step(); step();
    tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, done, trunc_err, align_err} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h done=%b te=%b ae=%b, want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, done, trunc_err, align_err);
    end
    rst = 1'b0; #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_sh_basic();
    int d0;
    d0 = done_cnt;
    mem_ack = 1'b1;
    issue(1'b0, 16'h0010, 32'hFFFF8001);
    tests++;
    if ({mem_we, mem_addr, mem_wdata, done, in_ready} !== {1'b1, 16'h0010, 16'h8001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL sh_beat: got we=%b addr=%h wd=%h done=%b rdy=%b want 1/0010/8001/0/0",
               mem_we, mem_addr, mem_wdata, done, in_ready);
    end
    step();
    tests++;
    if ({done, trunc_err, align_err, mem_we} !== 4'b1000) begin
      fails++;
      $display("FAIL sh_done: got done=%b te=%b ae=%b we=%b want 1/0/0/0", done, trunc_err, align_err, mem_we);
    end
    step();
    tests++;
    if ({done, in_ready} !== 2'b01 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL sh_idle: got done=%b rdy=%b pulses=%0d want 0/1/1", done, in_ready, done_cnt - d0);
    end
  endtask

  task automatic test_sh_trunc();
    logic [31:0] vals [2];
    logic [15:0] want [2];
    vals[0] = 32'h00012345;
    vals[1] = 32'h80000000;
`ifdef STORE_SAT_NARROW_EN
    want[0] = 16'h7FFF;
    want[1] = 16'h8000;
`else
    want[0] = 16'h2345;
    want[1] = 16'h0000;
`endif
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 16'h0040, vals[i]);
      tests++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0040, want[i]}) begin
        fails++;
        $display("FAIL sh_trunc_beat[%0d]: got we=%b addr=%h wd=%h want 1/0040/%h", i, mem_we, mem_addr, mem_wdata, want[i]);
      end
      step();
      tests++;
      if ({done, trunc_err, align_err} !== 3'b110) begin
        fails++;
        $display("FAIL sh_trunc_flag[%0d]: got done=%b te=%b ae=%b want 1/1/0", i, done, trunc_err, align_err);
      end
      step();
    end
  endtask

  task automatic test_sw_stall();
    int d0;
    d0 = done_cnt;
    mem_ack = 1'b0;
    issue(1'b1, 16'h0020, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 16'h0020, 16'hBEEF, 1'b0}) begin
        fails++;
        $display("FAIL sw_beat0[%0d]: got we=%b addr=%h wd=%h done=%b want 1/0020/beef/0", i, mem_we, mem_addr, mem_wdata, done);
      end
      if (i == 3) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 16'h0022, 16'hDEAD, 1'b0}) begin
        fails++;
        $display("FAIL sw_beat1[%0d]: got we=%b addr=%h wd=%h done=%b want 1/0022/dead/0", i, mem_we, mem_addr, mem_wdata, done);
      end
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    tests++;
    if ({done, trunc_err, align_err, mem_we} !== 4'b1000) begin
      fails++;
      $display("FAIL sw_done: got done=%b te=%b ae=%b we=%b want 1/0/0/0", done, trunc_err, align_err, mem_we);
    end
    step(); step();
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++; $display("FAIL sw_done_once: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_sw_wrap();
    mem_ack = 1'b1;
    issue(1'b1, 16'hFFFC, 32'h11112222);
    tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'hFFFC, 16'h2222}) begin
      fails++; $display("FAIL wrap_beat0: got we=%b addr=%h wd=%h want 1/fffc/2222", mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'hFFFE, 16'h1111}) begin
      fails++; $display("FAIL wrap_beat1: got we=%b addr=%h wd=%h want 1/fffe/1111", mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL wrap_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_misaligned();
    int w0;
    mem_ack = 1'b1;
    w0 = we_cnt;
    issue(1'b1, 16'hFFFE, 32'hCAFEF00D);
    tests++;
    if ({done, align_err, trunc_err, mem_we} !== 4'b1100) begin
      fails++; $display("FAIL sw_misalign: got done=%b ae=%b te=%b we=%b want 1/1/0/0", done, align_err, trunc_err, mem_we);
    end
    step();
    issue(1'b0, 16'h0013, 32'h00012345);
    tests++;
    if ({done, align_err, trunc_err, mem_we} !== 4'b1100) begin
      fails++; $display("FAIL sh_misalign: got done=%b ae=%b te=%b we=%b want 1/1/0/0", done, align_err, trunc_err, mem_we);
    end
    step();
    tests++;
    if (we_cnt != w0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL misalign_no_beat: got beats=%0d rdy=%b want 0/1", we_cnt - w0, in_ready);
    end
    issue(1'b0, 16'h0014, 32'h00000005);
    tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0014, 16'h0005}) begin
      fails++; $display("FAIL after_misalign: got we=%b addr=%h wd=%h want 1/0014/0005", mem_we, mem_addr, mem_wdata);
    end
    step(); step();
  endtask

  task automatic test_reset_mid();
    int d0;
    mem_ack = 1'b0;
    issue(1'b1, 16'h0030, 32'hAAAA5555);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    tests++;
    if ({mem_we, mem_addr} !== {1'b1, 16'h0032}) begin
      fails++; $display("FAIL mid_stall: got we=%b addr=%h want 1/0032", mem_we, mem_addr);
    end
    d0 = done_cnt;
    rst = 1'b1;
    step();
    tests++;
    if ({mem_we, done, in_ready} !== 3'b000) begin
      fails++; $display("FAIL mid_reset: got we=%b done=%b rdy=%b want 0/0/0", mem_we, done, in_ready);
    end
    rst = 1'b0; #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_ready: got %b want 1", in_ready);
    end
    mem_ack = 1'b1;
    step(); step(); step();
    tests++;
    if (done_cnt != d0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL mid_no_done: got pulses=%0d we=%b want 0/0", done_cnt - d0, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_sh_basic();
    test_sh_trunc();
    test_sw_stall();
    test_sw_wrap();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
